// File: rtl/crc_pkg.sv
// Shared types for the streaming CRC engine: FSM state, named CRC presets, bit reversal.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] poly;
    logic [31:0] init;
    logic        refin;
    logic        refout;
    logic [31:0] xorout;
  } crc_preset_t;

  localparam crc_preset_t CRC8 = '{
    poly: 32'h0000_0007, init: 32'h0000_0000,
    refin: 1'b0, refout: 1'b0, xorout: 32'h0000_0000
  };

  localparam crc_preset_t CRC16_CCITT_FALSE = '{
    poly: 32'h0000_1021, init: 32'h0000_FFFF,
    refin: 1'b0, refout: 1'b0, xorout: 32'h0000_0000
  };

  localparam crc_preset_t CRC32 = '{
    poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF,
    refin: 1'b1, refout: 1'b1, xorout: 32'hFFFF_FFFF
  };

  // Reverses the low n bits of x (n in 1..32); bits above n come back zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] x, input int unsigned n);
    logic [31:0] rev_all;
    rev_all = {<<{x}};
    return rev_all >> (32 - n);
  endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Beat input and result output bundle of crc_stream_engine. CRC_CHECK_EN adds exp_crc/crc_err.
interface crc_stream_engine_if #(
  parameter int CRC_W  = 8,
  parameter int DATA_W = 8
) ();

  // Both ports use strict valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; the source holds valid and its payload stable until that edge and
  // may not make valid depend on ready; the sink may change ready at any time.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              in_eof;
  logic              crc_valid;
  logic              crc_ready;
  logic [CRC_W-1:0]  crc_out;
  logic              busy;
`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0]  exp_crc;
  logic              crc_err;
`endif

  modport master (
    output in_valid, in_data, in_sof, in_eof, crc_ready,
`ifdef CRC_CHECK_EN
    output exp_crc,
    input  crc_err,
`endif
    input  in_ready, crc_valid, crc_out, busy
  );

  modport slave (
    input  in_valid, in_data, in_sof, in_eof, crc_ready,
`ifdef CRC_CHECK_EN
    input  exp_crc,
    output crc_err,
`endif
    output in_ready, crc_valid, crc_out, busy
  );

endinterface

// File: rtl/crc_fold_step.sv
// Combinational CRC update: folds DATA_W data bits, MSB-first, into the CRC register.
module crc_fold_step
  import crc_pkg::*;
#(
  parameter int          CRC_W      = 8,
  parameter int          DATA_W     = 8,
  parameter logic [31:0] POLY       = 32'h0000_0007,
  parameter bit          REFLECT_IN = 1'b0
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_next
);

  localparam logic [CRC_W-1:0] POLY_V = POLY[CRC_W-1:0];

  logic [31:0]       data_rev;
  logic [DATA_W-1:0] data_ord;
  logic [CRC_W-1:0]  acc;
  logic              fb;

  always_comb begin
    data_rev = bit_reverse(32'(data), DATA_W);
    data_ord = REFLECT_IN ? data_rev[DATA_W-1:0] : data;
    acc      = crc_in;
    fb       = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb  = acc[CRC_W-1] ^ data_ord[i];
      acc = (acc << 1) ^ (fb ? POLY_V : '0);
    end
    crc_next = acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: framed beats in, one held CRC result per frame out.
// Optional macro CRC_CHECK_EN adds the exp_crc compare and crc_err flag.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int          CRC_W       = 8,
  parameter int          DATA_W      = 8,
  parameter logic [31:0] POLY        = 32'h0000_0007,
  parameter logic [31:0] INIT        = 32'h0000_0000,
  parameter logic [31:0] XOR_OUT     = 32'h0000_0000,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  crc_stream_engine_if.slave  bus,
  output state_t              dbg_state
);

  localparam logic [CRC_W-1:0] INIT_V = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_V  = XOR_OUT[CRC_W-1:0];

  state_t           state;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] fold_base;
  logic [CRC_W-1:0] fold_next;
  logic [CRC_W-1:0] final_crc;
  logic [31:0]      final_rev;
  logic             in_ready_q;
  logic             crc_valid_q;
  logic             busy_q;
  logic [CRC_W-1:0] crc_out_q;
  logic             accept;
`ifdef CRC_CHECK_EN
  logic             crc_err_q;
`endif

  assign accept = bus.in_valid && in_ready_q;

  // An sof beat, or any beat arriving in IDLE, starts a fresh frame from INIT.
  assign fold_base = (state == IDLE || bus.in_sof) ? INIT_V : crc_q;

  crc_fold_step #(
    .CRC_W      (CRC_W),
    .DATA_W     (DATA_W),
    .POLY       (POLY),
    .REFLECT_IN (REFLECT_IN)
  ) u_fold (
    .crc_in   (fold_base),
    .data     (bus.in_data),
    .crc_next (fold_next)
  );

  always_comb begin
    final_rev = bit_reverse(32'(fold_next), CRC_W);
    final_crc = (REFLECT_OUT ? final_rev[CRC_W-1:0] : fold_next) ^ XOR_V;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      crc_q       <= INIT_V;
      in_ready_q  <= 1'b0;
      crc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      crc_out_q   <= '0;
`ifdef CRC_CHECK_EN
      crc_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            crc_q  <= fold_next;
            busy_q <= 1'b1;
            if (bus.in_eof) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              crc_valid_q <= 1'b1;
              crc_out_q   <= final_crc;
`ifdef CRC_CHECK_EN
              crc_err_q   <= (final_crc != bus.exp_crc);
`endif
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // crc_out/crc_err are only written on the eof beat, so they stay put here.
          if (crc_valid_q && bus.crc_ready) begin
            state       <= IDLE;
            crc_q       <= INIT_V;
            crc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          crc_q       <= INIT_V;
          crc_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.crc_valid = crc_valid_q;
  assign bus.crc_out   = crc_out_q;
  assign bus.busy      = busy_q;
`ifdef CRC_CHECK_EN
  assign bus.crc_err   = crc_err_q;
`endif
  assign dbg_state     = state;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: CRC8, CRC16_CCITT_FALSE and CRC32 instances behind one driver.
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

  int          sel;
  logic        in_valid_drv;
  logic        crc_ready_drv;
  logic [7:0]  data_drv;
  logic        sof_drv;
  logic        eof_drv;
  logic [31:0] exp_drv;

  crc_stream_engine_if #(.CRC_W(8),  .DATA_W(8)) if8  ();
  crc_stream_engine_if #(.CRC_W(16), .DATA_W(8)) if16 ();
  crc_stream_engine_if #(.CRC_W(32), .DATA_W(8)) if32 ();

  assign if8.in_valid   = in_valid_drv && (sel == 0);
  assign if16.in_valid  = in_valid_drv && (sel == 1);
  assign if32.in_valid  = in_valid_drv && (sel == 2);
  assign if8.crc_ready  = crc_ready_drv && (sel == 0);
  assign if16.crc_ready = crc_ready_drv && (sel == 1);
  assign if32.crc_ready = crc_ready_drv && (sel == 2);
  assign if8.in_data  = data_drv;
  assign if16.in_data = data_drv;
  assign if32.in_data = data_drv;
  assign if8.in_sof   = sof_drv;
  assign if16.in_sof  = sof_drv;
  assign if32.in_sof  = sof_drv;
  assign if8.in_eof   = eof_drv;
  assign if16.in_eof  = eof_drv;
  assign if32.in_eof  = eof_drv;
`ifdef CRC_CHECK_EN
  assign if8.exp_crc  = exp_drv[7:0];
  assign if16.exp_crc = exp_drv[15:0];
  assign if32.exp_crc = exp_drv;
`endif

  state_t st8, st16, st32;

  crc_stream_engine #(
    .CRC_W(8), .DATA_W(8), .POLY(CRC8.poly), .INIT(CRC8.init), .XOR_OUT(CRC8.xorout),
    .REFLECT_IN(CRC8.refin), .REFLECT_OUT(CRC8.refout)
  ) u_crc8 (.clk(clk), .reset(reset), .bus(if8.slave), .dbg_state(st8));

  crc_stream_engine #(
    .CRC_W(16), .DATA_W(8), .POLY(CRC16_CCITT_FALSE.poly), .INIT(CRC16_CCITT_FALSE.init),
    .XOR_OUT(CRC16_CCITT_FALSE.xorout), .REFLECT_IN(CRC16_CCITT_FALSE.refin),
    .REFLECT_OUT(CRC16_CCITT_FALSE.refout)
  ) u_crc16 (.clk(clk), .reset(reset), .bus(if16.slave), .dbg_state(st16));

  crc_stream_engine #(
    .CRC_W(32), .DATA_W(8), .POLY(CRC32.poly), .INIT(CRC32.init), .XOR_OUT(CRC32.xorout),
    .REFLECT_IN(CRC32.refin), .REFLECT_OUT(CRC32.refout)
  ) u_crc32 (.clk(clk), .reset(reset), .bus(if32.slave), .dbg_state(st32));

  // View of whichever instance sel points at.
  logic        cur_ready, cur_valid, cur_busy, cur_err;
  logic [31:0] cur_out;
  state_t      cur_state;

  always_comb begin
    cur_ready = if8.in_ready;
    cur_valid = if8.crc_valid;
    cur_busy  = if8.busy;
    cur_out   = 32'(if8.crc_out);
    cur_state = st8;
    cur_err   = 1'b0;
`ifdef CRC_CHECK_EN
    cur_err   = if8.crc_err;
`endif
    case (sel)
      1: begin
        cur_ready = if16.in_ready;
        cur_valid = if16.crc_valid;
        cur_busy  = if16.busy;
        cur_out   = 32'(if16.crc_out);
        cur_state = st16;
      end
      2: begin
        cur_ready = if32.in_ready;
        cur_valid = if32.crc_valid;
        cur_busy  = if32.busy;
        cur_out   = if32.crc_out;
        cur_state = st32;
      end
      default: ;
    endcase
  end

  // Reference model written in the table-free textbook forms (reflected shift-right for
  // reflected presets, shift-left otherwise).
  function automatic logic [31:0] rev_n(input logic [31:0] x, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[n-1-i] = x[i];
    return r;
  endfunction

  function automatic logic [31:0] crc_model(input crc_preset_t p, input int w,
                                            input logic [7:0] msg[$]);
    logic [31:0] mask, r, rp;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (p.refin) begin
      rp = rev_n(p.poly, w);
      r  = rev_n(p.init, w);
      foreach (msg[k]) begin
        r ^= {24'd0, msg[k]};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ rp) : (r >> 1);
      end
    end else begin
      r = p.init & mask;
      foreach (msg[k]) begin
        r ^= ({24'd0, msg[k]} << (w - 8));
        for (int b = 0; b < 8; b++)
          r = r[w-1] ? (((r << 1) ^ p.poly) & mask) : ((r << 1) & mask);
      end
    end
    return (r ^ p.xorout) & mask;
  endfunction

  function automatic crc_preset_t preset_of(input int s);
    return (s == 0) ? CRC8 : ((s == 1) ? CRC16_CCITT_FALSE : CRC32);
  endfunction

  function automatic int width_of(input int s);
    return (s == 0) ? 8 : ((s == 1) ? 16 : 32);
  endfunction

  logic [7:0] s9[$];

  // Driver: called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic sof, input logic eof,
                           output int cycles);
    logic acc;
    acc          = 1'b0;
    cycles       = 0;
    in_valid_drv = 1'b1;
    data_drv     = d;
    sof_drv      = sof;
    eof_drv      = eof;
    while (!acc && cycles < 50) begin
      acc = cur_ready;
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL beat_accept: in_ready never seen, got %0d cycles required <50", cycles);
    end
  endtask

  task automatic send_frame(input logic [7:0] msg[$], input logic [31:0] expv,
                            output int max_wait);
    int c;
    max_wait = 0;
    exp_q.push_back(expv);
    foreach (msg[k]) begin
      send_beat(msg[k], k == 0, k == msg.size() - 1, c);
      if (c > max_wait) max_wait = c;
    end
    in_valid_drv = 1'b0;
    sof_drv      = 1'b0;
    eof_drv      = 1'b0;
  endtask

  // Scoreboard side: wait for the held result, compare with the queue head, take it.
  task automatic get_result(input string name);
    int          waits;
    logic [31:0] expv;
    waits = 0;
    while (cur_valid !== 1'b1 && waits < 50) begin
      @(posedge clk);
      @(negedge clk);
      waits++;
    end
    compared++;
    if (cur_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_valid: crc_valid got %b required 1 within 50 cycles", name, cur_valid);
    end
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s_queue: result with empty queue, got %h required none", name, cur_out);
    end else begin
      expv = exp_q.pop_front();
      if (cur_out !== expv) begin
        mismatched++;
        $display("FAIL %s_crc: got %h required %h", name, cur_out, expv);
      end
    end
    crc_ready_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (cur_valid !== 1'b0 || cur_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_release: valid/ready got %b%b required 01", name, cur_valid, cur_ready);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    in_valid_drv  = 1'b0;
    crc_ready_drv = 1'b0;
    data_drv      = '0;
    sof_drv       = 1'b0;
    eof_drv       = 1'b0;
    exp_drv       = '0;
    sel           = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      compared++;
      if ({cur_ready, cur_valid, cur_busy, cur_err} !== 4'b0000 || cur_out !== 32'd0) begin
        mismatched++;
        $display("FAIL reset_outputs[%0d]: rdy/vld/busy/err got %b%b%b%b out %h required 0000 out 0",
                 s, cur_ready, cur_valid, cur_busy, cur_err, cur_out);
      end
    end
    sel = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (cur_ready !== 1'b1 || cur_state !== IDLE) begin
      mismatched++;
      $display("FAIL reset_release: in_ready got %b state %0d required 1 state 0",
               cur_ready, cur_state);
    end
  endtask

  task automatic test_single_beat();
    int c;
    sel           = 0;
    crc_ready_drv = 1'b1;
    exp_q.push_back(32'h07);
    send_beat(8'h01, 1'b1, 1'b1, c);
    in_valid_drv = 1'b0;
    compared++;
    if (cur_valid !== 1'b1 || cur_ready !== 1'b0 || cur_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_latency: vld/rdy/busy got %b%b%b required 101",
               cur_valid, cur_ready, cur_busy);
    end
    get_result("single_01");
    exp_q.push_back(32'hF3);
    send_beat(8'hFF, 1'b1, 1'b1, c);
    in_valid_drv = 1'b0;
    get_result("single_ff");
  endtask

  task automatic test_back_to_back();
    int         mw;
    logic [7:0] msg[$];
    sel = 0;
    send_frame(s9, 32'hF4, mw);
    compared++;
    if (mw !== 1) begin
      mismatched++;
      $display("FAIL b2b_ready: cycles per beat got %0d required 1", mw);
    end
    get_result("b2b_123456789");
    msg = {};
    for (int i = 0; i < 5; i++) msg.push_back(8'($urandom_range(0, 255)));
    send_frame(msg, crc_model(CRC8, 8, msg), mw);
    get_result("b2b_second");
  endtask

  task automatic test_presets();
    int mw;
    sel = 1;
    send_frame(s9, 32'h29B1, mw);
    get_result("crc16_ccitt");
    sel = 2;
    send_frame(s9, 32'hCBF43926, mw);
    get_result("crc32");
    sel = 0;
  endtask

  task automatic test_backpressure();
    int         mw;
    logic [7:0] one[$];
    sel           = 0;
    crc_ready_drv = 1'b0;
    send_frame(s9, 32'hF4, mw);
    in_valid_drv = 1'b1;
    data_drv     = 8'hAA;
    sof_drv      = 1'b1;
    eof_drv      = 1'b1;
    one          = '{8'hAA};
    exp_q.push_back(crc_model(CRC8, 8, one));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (cur_valid !== 1'b1 || cur_ready !== 1'b0 || cur_out !== 32'hF4 || cur_state !== HOLD) begin
        mismatched++;
        $display("FAIL hold_cycle%0d: vld/rdy got %b%b out %h state %0d required 10 out f4 state 2",
                 i, cur_valid, cur_ready, cur_out, cur_state);
      end
    end
    get_result("hold_frame");
    send_beat(8'hAA, 1'b1, 1'b1, mw);
    in_valid_drv = 1'b0;
    get_result("after_hold");
  endtask

  task automatic test_restart_and_reset();
    int mw;
    sel           = 0;
    crc_ready_drv = 1'b1;
    send_beat(8'h11, 1'b1, 1'b0, mw);
    send_beat(8'h22, 1'b0, 1'b0, mw);
    send_beat(8'h33, 1'b0, 1'b0, mw);
    send_frame(s9, 32'hF4, mw);
    get_result("sof_restart");
    send_beat(8'h55, 1'b1, 1'b0, mw);
    send_beat(8'h66, 1'b0, 1'b0, mw);
    in_valid_drv = 1'b0;
    compared++;
    if (cur_state !== ACCUM || cur_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL accum_state: state %0d busy %b required state 1 busy 1", cur_state, cur_busy);
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (cur_busy !== 1'b0 || cur_ready !== 1'b0 || cur_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: busy/rdy/vld got %b%b%b required 000", cur_busy, cur_ready, cur_valid);
    end
    reset = 1'b1;
    send_frame(s9, 32'hF4, mw);
    get_result("after_reset");
  endtask

  task automatic test_random();
    int         mw;
    int         len;
    logic [7:0] msg[$];
    for (int f = 0; f < 8; f++) begin
      sel           = $urandom_range(0, 2);
      crc_ready_drv = 1'b0;
      len           = $urandom_range(1, 6);
      msg           = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
      send_frame(msg, crc_model(preset_of(sel), width_of(sel), msg), mw);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      get_result("random");
    end
    sel = 0;
  endtask

`ifdef CRC_CHECK_EN
  task automatic test_check();
    int mw;
    sel           = 0;
    crc_ready_drv = 1'b0;
    exp_drv       = 32'hF4;
    send_frame(s9, 32'hF4, mw);
    compared++;
    if (cur_err !== 1'b0) begin
      mismatched++;
      $display("FAIL check_match: crc_err got %b required 0", cur_err);
    end
    get_result("check_match");
    crc_ready_drv = 1'b0;
    exp_drv       = 32'hF5;
    send_frame(s9, 32'hF4, mw);
    compared++;
    if (cur_err !== 1'b1) begin
      mismatched++;
      $display("FAIL check_mismatch: crc_err got %b required 1", cur_err);
    end
    get_result("check_mismatch");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_presets();
    test_backpressure();
    test_restart_and_reset();
    test_random();
`ifdef CRC_CHECK_EN
    test_check();
`endif
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: leftover entries got %0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
